axi_fft_master: RTL and testbench
=================================

// Module: axi_fft_master
// PURPOSE
//  AXI initiator that drives the FFT core's AXI slave bridge: writes one INCR burst of 16-bit samples,
//  waits for the FFT-done indication, then reads one INCR burst of 32-bit results back.
//  Sits between the sample source/result sink streams (valid/ready) and the FFT AXI port; used in SoC and bench.
// PARAMETERS
//  DATA_WIDTH  32  read-data width (R channel, result stream)
//  ID_W_WIDTH  2   AWID/BID width
//  ID_R_WIDTH  2   ARID width
//  TIMEOUT_CYC 1024 handshake watchdog limit (used only with AXI_FFT_MASTER_TIMEOUT_EN)
// PORTS
//  i_clk            in  1     clock
//  i_rstn           in  1     reset, asynchronous, active-low
//  i_start          in  1     start transaction pair; sampled only in IDLE
//  i_len            in  8     samples-1 (AxLEN value), latched on accepted i_start
//  i_wbase/i_rbase  in  12    write/read burst start byte address, latched on i_start
//  i_awid/i_arid    in  ID_W/ID_R  IDs, latched on i_start
//  i_calc_done      in  1     FFT finished (level); gates AR issue
//  i_smp_data       in  16    sample stream data;  i_smp_valid in 1; o_smp_ready out 1
//  o_res_data       out DATA_WIDTH result stream;  o_res_valid out 1; i_res_ready in 1
//  o_AWADDR 12, o_AWLEN 8, o_AWSIZE 3, o_AWBURST 2, o_AWID ID_W, o_AWVALID 1 out; i_AWREADY in 1
//  o_WDATA 16, o_WSTRB 2, o_WVALID 1, o_WLAST 1 out; i_WREADY in 1
//  i_BVALID 1, i_BID ID_W in; o_BREADY out 1
//  o_ARADDR 12, o_ARLEN 8, o_ARSIZE 3, o_ARBURST 2, o_ARID ID_R, o_ARVALID 1 out; i_ARREADY in 1
//  i_RDATA DATA_WIDTH, i_RVALID 1, i_RLAST 1 in; o_RREADY out 1
//  o_busy out 1 (state!=IDLE); o_done out 1 (1-cycle pulse); o_err out 1 (sticky until next i_start)
// BEHAVIOUR
//  Reset: state IDLE; all VALID/READY/LAST, o_busy, o_done, o_err = 0; beat counter 0; latched regs 0.
//  FSM: IDLE -i_start-> AW -AWVALID&AWREADY-> W -last beat accepted-> B -BVALID&BREADY-> WAIT_CALC
//       -i_calc_done-> AR -ARVALID&ARREADY-> R -last beat accepted-> DONE -> IDLE (o_done=1 in DONE).
//  AW/AR: VALID asserted registered on state entry, held with stable payload until READY; AxBURST=2'b01,
//   AWSIZE=3'b001 (2 B), ARSIZE=3'b010 (4 B), AxLEN=latched i_len.
//  W: o_WVALID=i_smp_valid, o_smp_ready=i_WREADY, o_WDATA=i_smp_data, o_WSTRB=2'b11 (combinational pass, W state only).
//   Beat counter (8b) increments on WVALID&WREADY; o_WLAST = (cnt==len). len=0 -> single beat with WLAST.
//  B: o_BREADY=1; BID != latched AWID -> o_err=1, flow continues.
//  R: o_RREADY=i_res_ready, o_res_valid=i_RVALID, o_res_data=i_RDATA (R state only); counter reused, cleared on R entry.
//   i_RLAST before cnt==len -> o_err=1, go DONE; cnt==len without RLAST -> o_err=1, go DONE.
//  i_start outside IDLE ignored; i_calc_done before WAIT_CALC has no effect (level re-checked there).
//  Stream ports idle (ready/valid 0) outside W/R. Reset mid-burst: immediate IDLE, all outputs to reset values.
// CONFIGURATION
//  AXI_FFT_MASTER_TIMEOUT_EN defined: counter of cycles without handshake in AW/W/B/AR/R; reaching TIMEOUT_CYC
//   -> o_err=1, deassert all VALID/READY, go DONE. WAIT_CALC not watched.
//  Undefined: no watchdog, FSM waits indefinitely; TIMEOUT_CYC unused.
// STRUCTURE
//  Package fft_axi_pkg: typedef enum master_fsm_e {M_IDLE,M_AW,M_W,M_B,M_WAIT_CALC,M_AR,M_R,M_DONE};
//   localparams AXBURST_INCR=2'b01, AXSIZE_2B=3'b001, AXSIZE_4B=3'b010.
//  Single module; watchdog counter inline under the macro; no sub-module.
// TESTING
//  1. i_len=3, wbase=0x000, all READY=1, samples 0x0001..0x0004 -> AWLEN=3, 4 W beats, WLAST on 4th, BREADY, stop in WAIT_CALC.
//  2. i_calc_done=1, rbase=0x000, 4 R beats 0xA0..0xA3 with RLAST on 4th, i_res_ready=1 -> 4 results out, o_done pulse, o_err=0.
//  3. i_len=0 -> one W beat with WLAST=1; i_AWREADY delayed 5 cycles -> AWVALID/AWADDR stable for 5 cycles.
//  4. i_res_ready toggles 1010 -> RREADY follows, no beat lost; RLAST on beat 2 of len=3 -> o_err=1, DONE.
//  5. i_rstn low during W beat 2 -> next cycle all VALID=0, o_busy=0; new i_start runs cleanly.
//  6. With AXI_FFT_MASTER_TIMEOUT_EN, TIMEOUT_CYC=16, i_BVALID held 0 -> o_err=1 after 16 cycles, o_done pulse.

Source files
------------

// File: rtl/fft_axi_pkg.sv
// rtl/fft_axi_pkg.sv - shared FSM encoding and AXI burst constants for the FFT AXI master
package fft_axi_pkg;

  typedef enum logic [2:0] {
    M_IDLE,
    M_AW,
    M_W,
    M_B,
    M_WAIT_CALC,
    M_AR,
    M_R,
    M_DONE
  } master_fsm_e;

  localparam logic [1:0] AXBURST_INCR = 2'b01;
  localparam logic [2:0] AXSIZE_2B    = 3'b001;
  localparam logic [2:0] AXSIZE_4B    = 3'b010;

endpackage

// File: rtl/axi_fft_master.sv
// rtl/axi_fft_master.sv - AXI initiator: sample write burst, wait for FFT done, result read burst
// Optional handshake watchdog enabled by defining AXI_FFT_MASTER_TIMEOUT_EN.
module axi_fft_master
  import fft_axi_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ID_W_WIDTH  = 2,
  parameter int ID_R_WIDTH  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [7:0]            i_len,
  input  logic [11:0]           i_wbase,
  input  logic [11:0]           i_rbase,
  input  logic [ID_W_WIDTH-1:0] i_awid,
  input  logic [ID_R_WIDTH-1:0] i_arid,
  input  logic                  i_calc_done,
  input  logic [15:0]           i_smp_data,
  input  logic                  i_smp_valid,
  output logic                  o_smp_ready,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [11:0]           o_AWADDR,
  output logic [7:0]            o_AWLEN,
  output logic [2:0]            o_AWSIZE,
  output logic [1:0]            o_AWBURST,
  output logic [ID_W_WIDTH-1:0] o_AWID,
  output logic                  o_AWVALID,
  input  logic                  i_AWREADY,
  output logic [15:0]           o_WDATA,
  output logic [1:0]            o_WSTRB,
  output logic                  o_WVALID,
  output logic                  o_WLAST,
  input  logic                  i_WREADY,
  input  logic                  i_BVALID,
  input  logic [ID_W_WIDTH-1:0] i_BID,
  output logic                  o_BREADY,
  output logic [11:0]           o_ARADDR,
  output logic [7:0]            o_ARLEN,
  output logic [2:0]            o_ARSIZE,
  output logic [1:0]            o_ARBURST,
  output logic [ID_R_WIDTH-1:0] o_ARID,
  output logic                  o_ARVALID,
  input  logic                  i_ARREADY,
  input  logic [DATA_WIDTH-1:0] i_RDATA,
  input  logic                  i_RVALID,
  input  logic                  i_RLAST,
  output logic                  o_RREADY,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  master_fsm_e           state;
  logic [7:0]            cnt;
  logic [7:0]            len_q;
  logic [11:0]           wbase_q;
  logic [11:0]           rbase_q;
  logic [ID_W_WIDTH-1:0] awid_q;
  logic [ID_R_WIDTH-1:0] arid_q;
  logic                  awvalid_q;
  logic                  arvalid_q;
  logic                  err_q;

  logic in_w;
  logic in_r;
  logic last_cnt;

  assign in_w     = (state == M_W);
  assign in_r     = (state == M_R);
  assign last_cnt = (cnt == len_q);

  assign o_AWADDR  = wbase_q;
  assign o_AWLEN   = len_q;
  assign o_AWSIZE  = AXSIZE_2B;
  assign o_AWBURST = AXBURST_INCR;
  assign o_AWID    = awid_q;
  assign o_AWVALID = awvalid_q;

  // W and R are pure pass-throughs between the streams and the AXI port
  assign o_WVALID    = in_w & i_smp_valid;
  assign o_smp_ready = in_w & i_WREADY;
  assign o_WDATA     = in_w ? i_smp_data : 16'h0000;
  assign o_WSTRB     = 2'b11;
  assign o_WLAST     = in_w & last_cnt;

  assign o_BREADY = (state == M_B);

  assign o_ARADDR  = rbase_q;
  assign o_ARLEN   = len_q;
  assign o_ARSIZE  = AXSIZE_4B;
  assign o_ARBURST = AXBURST_INCR;
  assign o_ARID    = arid_q;
  assign o_ARVALID = arvalid_q;

  assign o_RREADY    = in_r & i_res_ready;
  assign o_res_valid = in_r & i_RVALID;
  assign o_res_data  = in_r ? i_RDATA : '0;

  assign o_busy = (state != M_IDLE);
  assign o_done = (state == M_DONE);
  assign o_err  = err_q;

`ifdef AXI_FFT_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            watched;
  logic            hs;

  always_comb begin
    watched = 1'b0;
    hs      = 1'b0;
    case (state)
      M_AW:    begin watched = 1'b1; hs = awvalid_q & i_AWREADY;   end
      M_W:     begin watched = 1'b1; hs = i_smp_valid & i_WREADY;  end
      M_B:     begin watched = 1'b1; hs = i_BVALID;                end
      M_AR:    begin watched = 1'b1; hs = arvalid_q & i_ARREADY;   end
      M_R:     begin watched = 1'b1; hs = i_RVALID & i_res_ready;  end
      default: begin watched = 1'b0; hs = 1'b0;                    end
    endcase
  end
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= M_IDLE;
      cnt       <= 8'd0;
      len_q     <= 8'd0;
      wbase_q   <= 12'd0;
      rbase_q   <= 12'd0;
      awid_q    <= '0;
      arid_q    <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef AXI_FFT_MASTER_TIMEOUT_EN
      wd_cnt    <= '0;
`endif
    end else begin
      case (state)
        M_IDLE: begin
          if (i_start) begin
            len_q     <= i_len;
            wbase_q   <= i_wbase;
            rbase_q   <= i_rbase;
            awid_q    <= i_awid;
            arid_q    <= i_arid;
            err_q     <= 1'b0;
            cnt       <= 8'd0;
            awvalid_q <= 1'b1;
            state     <= M_AW;
          end
        end
        M_AW: begin
          if (i_AWREADY) begin
            awvalid_q <= 1'b0;
            cnt       <= 8'd0;
            state     <= M_W;
          end
        end
        M_W: begin
          if (i_smp_valid && i_WREADY) begin
            if (last_cnt) begin
              cnt   <= 8'd0;
              state <= M_B;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        M_B: begin
          if (i_BVALID) begin
            if (i_BID != awid_q) err_q <= 1'b1;
            state <= M_WAIT_CALC;
          end
        end
        M_WAIT_CALC: begin
          if (i_calc_done) begin
            arvalid_q <= 1'b1;
            state     <= M_AR;
          end
        end
        M_AR: begin
          if (i_ARREADY) begin
            arvalid_q <= 1'b0;
            cnt       <= 8'd0;
            state     <= M_R;
          end
        end
        M_R: begin
          // Burst length mismatch in either direction ends the read early and flags an error
          if (i_RVALID && i_res_ready) begin
            if (last_cnt) begin
              if (!i_RLAST) err_q <= 1'b1;
              state <= M_DONE;
            end else if (i_RLAST) begin
              err_q <= 1'b1;
              state <= M_DONE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        M_DONE:  state <= M_IDLE;
        default: state <= M_IDLE;
      endcase

`ifdef AXI_FFT_MASTER_TIMEOUT_EN
      if (!watched || hs) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
        wd_cnt    <= '0;
        err_q     <= 1'b1;
        awvalid_q <= 1'b0;
        arvalid_q <= 1'b0;
        state     <= M_DONE;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_fft_master.sv
// tb/tb_axi_fft_master.sv - scoreboard bench for axi_fft_master with randomized AXI slave timing
module tb_axi_fft_master;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_len = 8'd0;
  logic [11:0] i_wbase = 12'd0;
  logic [11:0] i_rbase = 12'd0;
  logic [1:0]  i_awid = 2'd0;
  logic [1:0]  i_arid = 2'd0;
  logic        i_calc_done = 1'b0;
  logic [15:0] i_smp_data = 16'd0;
  logic        i_smp_valid = 1'b0;
  logic        o_smp_ready;
  logic [31:0] o_res_data;
  logic        o_res_valid;
  logic        i_res_ready = 1'b0;
  logic [11:0] o_AWADDR;
  logic [7:0]  o_AWLEN;
  logic [2:0]  o_AWSIZE;
  logic [1:0]  o_AWBURST;
  logic [1:0]  o_AWID;
  logic        o_AWVALID;
  logic        i_AWREADY = 1'b0;
  logic [15:0] o_WDATA;
  logic [1:0]  o_WSTRB;
  logic        o_WVALID;
  logic        o_WLAST;
  logic        i_WREADY = 1'b0;
  logic        i_BVALID = 1'b0;
  logic [1:0]  i_BID = 2'd0;
  logic        o_BREADY;
  logic [11:0] o_ARADDR;
  logic [7:0]  o_ARLEN;
  logic [2:0]  o_ARSIZE;
  logic [1:0]  o_ARBURST;
  logic [1:0]  o_ARID;
  logic        o_ARVALID;
  logic        i_ARREADY = 1'b0;
  logic [31:0] i_RDATA = 32'd0;
  logic        i_RVALID = 1'b0;
  logic        i_RLAST = 1'b0;
  logic        o_RREADY;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  axi_fft_master #(
    .DATA_WIDTH(32), .ID_W_WIDTH(2), .ID_R_WIDTH(2), .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_len(i_len),
    .i_wbase(i_wbase), .i_rbase(i_rbase), .i_awid(i_awid), .i_arid(i_arid),
    .i_calc_done(i_calc_done), .i_smp_data(i_smp_data), .i_smp_valid(i_smp_valid),
    .o_smp_ready(o_smp_ready), .o_res_data(o_res_data), .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready), .o_AWADDR(o_AWADDR), .o_AWLEN(o_AWLEN), .o_AWSIZE(o_AWSIZE),
    .o_AWBURST(o_AWBURST), .o_AWID(o_AWID), .o_AWVALID(o_AWVALID), .i_AWREADY(i_AWREADY),
    .o_WDATA(o_WDATA), .o_WSTRB(o_WSTRB), .o_WVALID(o_WVALID), .o_WLAST(o_WLAST),
    .i_WREADY(i_WREADY), .i_BVALID(i_BVALID), .i_BID(i_BID), .o_BREADY(o_BREADY),
    .o_ARADDR(o_ARADDR), .o_ARLEN(o_ARLEN), .o_ARSIZE(o_ARSIZE), .o_ARBURST(o_ARBURST),
    .o_ARID(o_ARID), .o_ARVALID(o_ARVALID), .i_ARREADY(i_ARREADY), .i_RDATA(i_RDATA),
    .i_RVALID(i_RVALID), .i_RLAST(i_RLAST), .o_RREADY(o_RREADY), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  len;
    logic [1:0]  id;
  } ax_t;

  ax_t         aw_q[$];
  ax_t         ar_q[$];
  logic [16:0] w_q[$];
  logic [31:0] res_q[$];
  logic        done_q[$];

  logic [15:0] smp_arr[256];
  logic [31:0] rd_arr[256];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [9:0] idle_outputs();
    return {o_AWVALID, o_WVALID, o_smp_ready, o_BREADY, o_ARVALID,
            o_RREADY, o_res_valid, o_busy, o_done, o_err};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT completes a handshake
  logic        aw_stall = 1'b0;
  logic [11:0] aw_prev  = 12'd0;

  always @(negedge i_clk) begin
    if (!i_rstn) begin
      aw_stall = 1'b0;
    end else begin
      if (aw_stall) begin
        chk("aw_hold_valid", o_AWVALID, 1'b1);
        chk("aw_hold_addr", o_AWADDR, aw_prev);
      end
      aw_stall = o_AWVALID && !i_AWREADY;
      aw_prev  = o_AWADDR;
      if (o_AWVALID && i_AWREADY) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
        else begin
          ax_t e;
          e = aw_q.pop_front();
          chk("awaddr", o_AWADDR, e.addr);
          chk("awlen", o_AWLEN, e.len);
          chk("awid", o_AWID, e.id);
          chk("awsize_burst", {o_AWSIZE, o_AWBURST}, {3'b001, 2'b01});
        end
      end
      if (o_WVALID && i_WREADY) begin
        if (w_q.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
        else begin
          logic [16:0] e;
          e = w_q.pop_front();
          chk("w_beat", {o_WLAST, o_WDATA}, e);
          chk("wstrb", o_WSTRB, 2'b11);
        end
      end
      if (o_ARVALID && i_ARREADY) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
        else begin
          ax_t e;
          e = ar_q.pop_front();
          chk("araddr", o_ARADDR, e.addr);
          chk("arlen", o_ARLEN, e.len);
          chk("arid", o_ARID, e.id);
          chk("arsize_burst", {o_ARSIZE, o_ARBURST}, {3'b010, 2'b01});
        end
      end
      if (o_res_valid && i_res_ready) begin
        chk("rready_follows", o_RREADY, 1'b1);
        if (res_q.size() == 0) chk("res_unexpected", 1'b1, 1'b0);
        else chk("res_data", o_res_data, res_q.pop_front());
      end
      if (o_done) begin
        chk("busy_in_done", o_busy, 1'b1);
        if (done_q.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
        else chk("done_err", o_err, done_q.pop_front());
      end
    end
  end

  function automatic bit rnd();
    return $urandom_range(0, 2) != 0;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      smp_arr[i] = 16'($urandom);
      rd_arr[i]  = $urandom;
    end
  endtask

  task automatic drive_idle();
    i_start = 0; i_smp_valid = 0; i_AWREADY = 0; i_WREADY = 0; i_BVALID = 0;
    i_calc_done = 0; i_ARREADY = 0; i_RVALID = 0; i_RLAST = 0; i_res_ready = 0;
  endtask

  // rlast_at: beat index carrying RLAST (-1 never); abort_at: W beat at which reset is asserted
  task automatic run_txn(input int len, input bit full_rdy, input int aw_delay, input bit toggle_rr,
                         input int rlast_at, input bit bad_bid, input bit hold_b, input int abort_at);
    ax_t a;
    int  nbeats, si, ri, cyc, bneg, aw_stalls;
    bit  aw_d, w_d, b_d, ar_d, calc, rv_pend, fin, exp_err;
    logic [11:0] wbase, rbase;
    logic [1:0]  awid, arid;
    wbase = 12'($urandom); rbase = 12'($urandom);
    awid = 2'($urandom); arid = 2'($urandom);
    a.addr = wbase; a.len = 8'(len); a.id = awid;
    aw_q.push_back(a);
    for (int i = 0; i <= len; i++) w_q.push_back({(i == len), smp_arr[i]});
    if (hold_b) begin
      exp_err = 1'b1;
    end else begin
      a.addr = rbase; a.id = arid;
      ar_q.push_back(a);
      nbeats = (rlast_at >= 0 && rlast_at < len) ? rlast_at + 1 : len + 1;
      for (int i = 0; i < nbeats; i++) res_q.push_back(rd_arr[i]);
      exp_err = bad_bid || (rlast_at != len);
    end
    done_q.push_back(exp_err);

    @(posedge i_clk); #1;
    i_start = 1; i_len = 8'(len); i_wbase = wbase; i_rbase = rbase; i_awid = awid; i_arid = arid;
    @(posedge i_clk); #1;
    i_start = 0;
    {si, ri, cyc, bneg, aw_stalls} = '0;
    {aw_d, w_d, b_d, ar_d, calc, rv_pend, fin} = '0;
    while (!fin && cyc < 3000) begin
      i_AWREADY   = full_rdy ? 1'b1 : (aw_delay > 0 ? (cyc >= aw_delay) : rnd());
      i_smp_valid = (si <= len) && (full_rdy || rnd());
      i_smp_data  = (si <= len) ? smp_arr[si] : 16'h0;
      i_WREADY    = full_rdy || rnd();
      i_BVALID    = w_d && !b_d && !hold_b;
      i_BID       = bad_bid ? ~awid : awid;
      if (b_d && (full_rdy || rnd())) calc = 1;
      i_calc_done = calc;
      i_ARREADY   = full_rdy || rnd();
      i_RVALID    = ar_d && (ri < nbeats) && (rv_pend || full_rdy || rnd());
      i_RDATA     = (ri < 256) ? rd_arr[ri] : 32'h0;
      i_RLAST     = (ri == rlast_at);
      i_res_ready = toggle_rr ? (cyc % 2 == 0) : (full_rdy || rnd());
      if (abort_at >= 0 && si == abort_at) begin
        i_rstn = 0;
        break;
      end
      @(negedge i_clk);
      if (o_AWVALID && !i_AWREADY) aw_stalls++;
      if (o_AWVALID && i_AWREADY) aw_d = 1;
      if (o_WVALID && i_WREADY) begin
        si++;
        if (o_WLAST) w_d = 1;
      end
      if (o_BREADY && i_BVALID) b_d = 1;
      if (o_BREADY && !i_BVALID) bneg++;
      if (o_ARVALID && i_ARREADY) ar_d = 1;
      if (i_RVALID) rv_pend = !o_RREADY;
      if (o_RREADY && i_RVALID) ri++;
      if (o_done) fin = 1;
      @(posedge i_clk); #1;
      cyc++;
    end
    if (abort_at >= 0) begin
      @(negedge i_clk);
      chk("midburst_reset_outputs", idle_outputs(), 10'b0);
      aw_q.delete(); ar_q.delete(); w_q.delete(); res_q.delete(); done_q.delete();
      drive_idle();
      @(posedge i_clk); #1;
      i_rstn = 1;
    end else begin
      chk("txn_complete", fin, 1'b1);
      if (aw_delay > 0) chk("aw_stall_cycles", aw_stalls, aw_delay);
`ifdef AXI_FFT_MASTER_TIMEOUT_EN
      if (hold_b) chk("watchdog_cycles", bneg, 16);
`endif
      drive_idle();
      @(negedge i_clk);
      chk("idle_busy", o_busy, 1'b0);
      chk("err_sticky", o_err, exp_err);
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    drive_idle();
    i_rstn = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_outputs", idle_outputs(), 10'b0);
    @(posedge i_clk); #1;
    i_rstn = 1;

    for (int i = 0; i < 4; i++) begin
      smp_arr[i] = 16'(i + 1);
      rd_arr[i]  = 32'(8'hA0 + i);
    end
    run_txn(3, 1, 0, 0, 3, 0, 0, -1);

    fill_random();
    run_txn(0, 0, 5, 0, 0, 0, 0, -1);
    fill_random();
    run_txn(3, 0, 0, 1, 1, 0, 0, -1);
    fill_random();
    run_txn(2, 0, 0, 0, -1, 0, 0, -1);
    fill_random();
    run_txn(5, 0, 0, 0, 5, 1, 0, -1);

    fill_random();
    run_txn(3, 1, 0, 0, 3, 0, 0, 2);
    fill_random();
    run_txn(3, 1, 0, 0, 3, 0, 0, -1);

    for (int k = 0; k < 10; k++) begin
      int len, sel, rl;
      fill_random();
      len = $urandom_range(0, 20);
      sel = $urandom_range(0, 3);
      rl  = (sel == 0) ? -1 : (sel == 1 && len > 0) ? $urandom_range(0, len - 1) : len;
      run_txn(len, 0, 0, 0, rl, ($urandom_range(0, 3) == 0), 0, -1);
    end

`ifdef AXI_FFT_MASTER_TIMEOUT_EN
    fill_random();
    run_txn(2, 1, 0, 0, 2, 0, 1, -1);
`endif

    chk("queues_drained", {32'(aw_q.size() + ar_q.size()), 32'(w_q.size() + res_q.size() + done_q.size())}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
